// File: rtl/col_rr_arbiter_if.sv
// Column-request / single-output channel bundle for col_rr_arbiter.
// master is the arbiter's view; slave is the view of the sources and the consumer.
interface col_rr_arbiter_if #(
    parameter int COLS = 4,
    parameter int DW   = 2
);
    localparam int IW = $clog2(COLS);

    logic [COLS-1:0]         ival;
    logic [COLS-1:0][DW-1:0] idata;
    logic [COLS-1:0]         iready;
    logic                    oval;
    logic [DW-1:0]           odata;
    logic [IW-1:0]           ocol;
    logic                    oready;

    modport master (
        input  ival, idata, oready,
        output iready, oval, odata, ocol
    );

    modport slave (
        output ival, idata, oready,
        input  iready, oval, odata, ocol
    );
endinterface

// File: rtl/col_rr_arbiter.sv
// Round-robin arbiter sharing one registered output slot among COLS column requesters.
// The pointer names the highest-priority column and moves only past a granted column.
module col_rr_arbiter #(
    parameter int COLS = 4,
    parameter int DW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    col_rr_arbiter_if.master      bus
);
    localparam int IW = $clog2(COLS);

    typedef enum logic {EMPTY, FULL} slot_t;

    slot_t           state, state_nxt;
    logic [IW-1:0]   ptr, ptr_nxt;
    logic [DW-1:0]   odata_q;
    logic [IW-1:0]   ocol_q;
    logic [COLS-1:0] grant;
    logic [IW-1:0]   sel;
    logic [IW:0]     idx;
    logic            found;
    logic            slot_free;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        grant     = '0;
        sel       = '0;
        idx       = '0;
        found     = 1'b0;
        slot_free = (state == EMPTY) || bus.oready;
        // Scan starts at ptr and wraps modulo COLS; one extra bit keeps the sum exact for non-power-of-2 COLS.
        if (slot_free && !rst) begin
            for (int unsigned i = 0; i < COLS; i++) begin
                idx = {1'b0, ptr} + (IW+1)'(i);
                if (idx >= (IW+1)'(COLS)) begin
                    idx = idx - (IW+1)'(COLS);
                end
                if (!found && bus.ival[idx[IW-1:0]]) begin
                    found = 1'b1;
                    sel   = idx[IW-1:0];
                end
            end
        end
        if (found) begin
            grant[sel] = 1'b1;
            state_nxt  = FULL;
            ptr_nxt    = (sel == IW'(COLS - 1)) ? '0 : sel + 1'b1;
        end else if ((state == FULL) && bus.oready) begin
            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            ptr     <= '0;
            odata_q <= '0;
            ocol_q  <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            if (found) begin
                odata_q <= bus.idata[sel];
                ocol_q  <= sel;
            end
        end
    end

    assign bus.iready = grant;
    assign bus.oval   = (state == FULL);
    assign bus.odata  = odata_q;
    assign bus.ocol   = ocol_q;
endmodule

// File: tb/tb_col_rr_arbiter.sv
// Directed bench for col_rr_arbiter: a COLS=4 instance and a COLS=3 instance,
// hand-computed expectations checked through one task.
module tb_col_rr_arbiter;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    col_rr_arbiter_if #(.COLS(4), .DW(2)) ifa ();
    col_rr_arbiter_if #(.COLS(3), .DW(2)) ifb ();

    col_rr_arbiter #(.COLS(4), .DW(2)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
    col_rr_arbiter #(.COLS(3), .DW(2)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Protocol and output-stage properties
    a_onehot_a: assert property (@(posedge clk) $onehot0(ifa.iready));
    a_onehot_b: assert property (@(posedge clk) $onehot0(ifb.iready));
    a_stall_a: assert property (@(posedge clk) disable iff (rst_a)
        ifa.oval && !ifa.oready |=> $stable({ifa.oval, ifa.odata, ifa.ocol}));
    a_stall_b: assert property (@(posedge clk) disable iff (rst_b)
        ifb.oval && !ifb.oready |=> $stable({ifb.oval, ifb.odata, ifb.ocol}));
    for (genvar k = 0; k < 4; k++) begin : g_hold_a
        a_hold: assert property (@(posedge clk) disable iff (rst_a)
            ifa.ival[k] && !ifa.iready[k] |=> ifa.ival[k] && $stable(ifa.idata[k]));
    end
    for (genvar k = 0; k < 3; k++) begin : g_hold_b
        a_hold: assert property (@(posedge clk) disable iff (rst_b)
            ifb.ival[k] && !ifb.iready[k] |=> ifb.ival[k] && $stable(ifb.idata[k]));
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.ival   = 4'hF;
        ifa.idata  = {2'd3, 2'd2, 2'd1, 2'd0};
        ifa.oready = 1'b1;
        ifb.ival   = 3'b000;
        ifb.idata  = {2'd2, 2'd1, 2'd0};
        ifb.oready = 1'b1;

        // Reset held with all columns requesting
        tick();
        tick();
        check("rst_iready", 32'(ifa.iready), 32'h0);
        check("rst_oval",   32'(ifa.oval),   32'h0);
        check("rst_ocol",   32'(ifa.ocol),   32'h0);
        check("rst_odata",  32'(ifa.odata),  32'h0);
        #3;
        rst_a = 1'b0;
        #1;
        check("first_grant", 32'(ifa.iready), 32'h1);

        // All request, continuous drain: 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_oval",   32'(ifa.oval),   32'h1);
            check("rr_ocol",   32'(ifa.ocol),   32'(i % 4));
            check("rr_odata",  32'(ifa.odata),  32'(i % 4));
            check("rr_iready", 32'(ifa.iready), 32'(1 << ((i + 1) % 4)));
        end

        // Bring col 2 into the slot, then stall
        tick();
        tick();
        ifa.oready = 1'b0;
        #1;
        check("bp_ocol0",   32'(ifa.ocol),   32'h2);
        check("bp_iready0", 32'(ifa.iready), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_oval",   32'(ifa.oval),   32'h1);
            check("bp_ocol",   32'(ifa.ocol),   32'h2);
            check("bp_odata",  32'(ifa.odata),  32'h2);
            check("bp_iready", 32'(ifa.iready), 32'h0);
        end
        ifa.oready = 1'b1;
        #1;
        check("bp_release_grant", 32'(ifa.iready), 32'h8);
        tick();
        check("bp_reload_ocol",  32'(ifa.ocol),  32'h3);
        check("bp_reload_odata", 32'(ifa.odata), 32'h3);
        check("bp_reload_oval",  32'(ifa.oval),  32'h1);

        // Single requester col 2
        rst_a    = 1'b1;
        ifa.ival = 4'h0;
        #1;
        check("rst2_oval", 32'(ifa.oval), 32'h0);
        tick();
        ifa.ival = 4'h4;
        #1;
        check("rst2_iready", 32'(ifa.iready), 32'h0);
        rst_a = 1'b0;
        #1;
        check("single_grant0", 32'(ifa.iready), 32'h4);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("single_oval",   32'(ifa.oval),   32'h1);
            check("single_ocol",   32'(ifa.ocol),   32'h2);
            check("single_iready", 32'(ifa.iready), 32'h4);
        end

        // Drain without refill, then idle must not rotate priority (ptr stays 3)
        ifa.ival = 4'h0;
        tick();
        check("drain_oval",  32'(ifa.oval),  32'h0);
        check("drain_ocol",  32'(ifa.ocol),  32'h2);
        check("drain_odata", 32'(ifa.odata), 32'h2);
        tick();
        ifa.ival = 4'hF;
        #1;
        check("idle_keeps_ptr", 32'(ifa.iready), 32'h8);
        rst_a    = 1'b1;
        ifa.ival = 4'h0;

        // COLS=3, all request: 0,1,2,0,1
        ifb.ival = 3'b111;
        tick();
        #3;
        rst_b = 1'b0;
        #1;
        check("c3_first_grant", 32'(ifb.iready), 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("c3_oval",   32'(ifb.oval),   32'h1);
            check("c3_ocol",   32'(ifb.ocol),   32'(i % 3));
            check("c3_odata",  32'(ifb.odata),  32'(i % 3));
            check("c3_iready", 32'(ifb.iready), 32'(1 << ((i + 1) % 3)));
        end

        // Stall, then asynchronous reset between edges
        ifb.oready = 1'b0;
        #1;
        check("c3_stall_iready", 32'(ifb.iready), 32'h0);
        check("c3_stall_oval",   32'(ifb.oval),   32'h1);
        #2;
        rst_b = 1'b1;
        #1;
        check("async_oval",   32'(ifb.oval),   32'h0);
        check("async_ocol",   32'(ifb.ocol),   32'h0);
        check("async_odata",  32'(ifb.odata),  32'h0);
        check("async_iready", 32'(ifb.iready), 32'h0);
        tick();
        ifb.ival   = 3'b110;
        ifb.oready = 1'b1;
        #2;
        rst_b = 1'b0;
        #1;
        check("post_rst_grant", 32'(ifb.iready), 32'h2);
        tick();
        check("post_rst_ocol",  32'(ifb.ocol),   32'h1);
        check("post_rst_odata", 32'(ifb.odata),  32'h1);
        check("post_rst_next",  32'(ifb.iready), 32'h4);
        tick();
        check("post_rst_ocol2", 32'(ifb.ocol),   32'h2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
